traffic_checker: RTL and testbench
==================================

# traffic_checker

Passive protocol checker on the receiving end of the four-way signal-light bus. It samples the eight 2-bit lamp codes (N/S/E/W car and pedestrian) plus the 7-bit frame cycle number on every clock and flags cross-axis conflicts, illegal codes, out-of-order lamp sequences, wrong phase durations, north/south or east/west pair mismatches, and cycle-counter discontinuities. It sits beside the intersection controller in the top level and never drives the lamps.

## Interface
- P_FRAME, 68: last cycle number of a frame; the frame wraps P_FRAME -> 1.
- P_GREEN, 20 / P_YELLOW, 2 / P_LEFT, 10 / P_RED, 34: required car dwell in cycles.
- P_PGREEN, 14 / P_PBLINK, 6 / P_PRED, 48: required pedestrian dwell in cycles.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_clr  in  1  synchronous clear of the sticky error flags, o_err_cnt and o_err_cyc.
- n_car, s_car, e_car, w_car  in  2 each  car lamp codes: 00 RED, 01 GREEN, 10 YELLOW, 11 LEFT.
- n_ped, s_ped, e_ped, w_ped  in  2 each  pedestrian lamp codes: 00 RED, 01 GREEN, 10 BLINK, 11 illegal.
- i_cycle  in  7  controller cycle number (0 = idle).
- o_err_conf, o_err_code, o_err_seq, o_err_time, o_err_pair, o_err_cyc_jump  out  1 each  sticky error flags.
- o_err_any  out  1  OR of all sticky flags (registered).
- o_err_cyc  out  7  i_cycle value sampled with the first error since reset or clear.
- o_err_cnt  out  8  number of samples containing at least one error; saturates at 255.

## Operation
- Axis NS is tracked from n_car/n_ped and axis EW from e_car/e_ped. The s_* and w_* inputs are used only in the pair check.
- Checks per sample (one "sample" = input values at a posedge):
  - conf: both n_car and e_car are non-RED, or a ped lamp is non-RED while the same axis car lamp is non-RED.
  - code: any ped input equals 11.
  - pair: n_car≠s_car, n_ped≠s_ped, e_car≠w_car, or e_ped≠w_ped.
  - seq: a lamp code differs from the previous sample and the transition is not legal.
    - Legal car transitions: RED->GREEN, GREEN->YELLOW, YELLOW->LEFT (only when the yellow followed GREEN), YELLOW->RED (only when the yellow followed LEFT), LEFT->YELLOW.
    - Legal ped transitions: RED->GREEN, GREEN->BLINK, BLINK->RED.
    - A per-axis bit records whether the current yellow followed GREEN or LEFT.
    - Transitions into or out of ped code 11 are exempt from seq.
  - time: per-lamp dwell counter (7 bits, saturating at 127).
    - On a code change, the counter must equal the parameter for the old code; otherwise time is flagged.
    - After the check the counter loads 1; while the code is unchanged it increments.
    - Each lamp's check is disarmed after reset and arms on that lamp's first legal change out of RED. This covers the idle red and the first partial red.
  - cyc_jump: with previous sample p, the current i_cycle is legal only if:
    - p=0 and current is 0 or 1;
    - p=P_FRAME and current is 1;
    - otherwise current is p+1.
- Any failing check sets its sticky flag and increments o_err_cnt once per sample, even if several checks fail.
- o_err_cyc captures i_cycle only when all flags are currently clear.
- i_clr and a new error in the same sample: the error wins.
  - Flags from that sample are set, o_err_cnt becomes 1, and o_err_cyc captures the current cycle.
- i_clr does not reset previous-sample registers, dwell counters or arm bits.

## Timing
- All outputs are registered and appear one cycle after the posedge at which the offending sample is taken.
- Reset (rst=1 at a posedge) sets the following to 0: all flags, o_err_any, o_err_cyc, o_err_cnt, dwell counters, arm bits, yellow-origin bits and previous-sample registers (previous cycle 0, previous lamps RED).
- The first sample after reset is compared against these previous values.
- Reset asserted mid-frame takes priority over all checks in that cycle.

## Test plan
- Drive the intersection controller for 3 full frames (cycles 0..68, wrap to 1) -> all flags stay 0 and o_err_cnt=0.
- Force e_car=01 while n_car=01 at i_cycle=5 -> o_err_conf=1 the next cycle, o_err_cyc=5, o_err_cnt=1; no other flag is set.
- Hold NS yellow for 1 cycle (cycle 21 only, LEFT at 22) -> o_err_time=1, o_err_cyc=22.
- Drive n_car GREEN->LEFT directly -> o_err_seq=1. Drive n_ped=11 with s_ped=11 -> o_err_code=1 only.
- Set s_car≠n_car at cycle 40 -> o_err_pair=1. Drive i_cycle 10->12 -> o_err_cyc_jump=1. Drive 68->0 -> o_err_cyc_jump=1.
- Assert i_clr in the same cycle as a conflict -> o_err_conf=1 and o_err_cnt=1. Keep errors for 300 samples -> o_err_cnt holds at 255.

Source files
------------

// File: rtl/traffic_checker.sv
// traffic_checker: passive checker for the four-way signal-light bus.
// Samples the lamp codes and frame cycle on every clock and raises sticky
// error flags for conflicts, illegal codes, bad sequences, wrong dwell times,
// N/S or E/W pair mismatches and cycle-counter discontinuities.
module traffic_checker #(
  parameter int unsigned P_FRAME  = 68,
  parameter int unsigned P_GREEN  = 20,
  parameter int unsigned P_YELLOW = 2,
  parameter int unsigned P_LEFT   = 10,
  parameter int unsigned P_RED    = 34,
  parameter int unsigned P_PGREEN = 14,
  parameter int unsigned P_PBLINK = 6,
  parameter int unsigned P_PRED   = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic [1:0] n_car,
  input  logic [1:0] s_car,
  input  logic [1:0] e_car,
  input  logic [1:0] w_car,
  input  logic [1:0] n_ped,
  input  logic [1:0] s_ped,
  input  logic [1:0] e_ped,
  input  logic [1:0] w_ped,
  input  logic [6:0] i_cycle,
  output logic       o_err_conf,
  output logic       o_err_code,
  output logic       o_err_seq,
  output logic       o_err_time,
  output logic       o_err_pair,
  output logic       o_err_cyc_jump,
  output logic       o_err_any,
  output logic [6:0] o_err_cyc,
  output logic [7:0] o_err_cnt
);

  typedef enum logic [1:0] {
    CAR_RED    = 2'b00,
    CAR_GREEN  = 2'b01,
    CAR_YELLOW = 2'b10,
    CAR_LEFT   = 2'b11
  } car_e;

  typedef enum logic [1:0] {
    PED_RED   = 2'b00,
    PED_GREEN = 2'b01,
    PED_BLINK = 2'b10,
    PED_BAD   = 2'b11
  } ped_e;

  // Tracked lamps: [0] n_car, [1] n_ped, [2] e_car, [3] e_ped
  logic [3:0][1:0] cur;
  logic [3:0][1:0] prev_q, prev_d;
  logic [3:0][6:0] dwell_q, dwell_d;
  logic [3:0]      arm_q, arm_d;
  logic [1:0]      ylf_q, ylf_d;     // per axis: current yellow followed LEFT
  logic [6:0]      cyc_q;
  logic [5:0]      flags_q, flags_d; // {conf, code, seq, time, pair, jump}
  logic            any_q, any_d;
  logic [6:0]      ecyc_q, ecyc_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            e_conf, e_code, e_seq, e_time, e_pair, e_jump;
  logic [5:0]      new_err;
  logic            new_any;
  logic [1:0]      p_code, c_code;
  logic            legal, exempt, is_ped;
  logic [7:0]      cyc_next;

  assign cur = {e_ped, e_car, n_ped, n_car};

  function automatic logic car_legal(input logic [1:0] p, input logic [1:0] c,
                                     input logic yl);
    logic ok;
    ok = 1'b0;
    case ({p, c})
      {CAR_RED,    CAR_GREEN}:  ok = 1'b1;
      {CAR_GREEN,  CAR_YELLOW}: ok = 1'b1;
      {CAR_YELLOW, CAR_LEFT}:   ok = !yl;
      {CAR_YELLOW, CAR_RED}:    ok = yl;
      {CAR_LEFT,   CAR_YELLOW}: ok = 1'b1;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic ped_legal(input logic [1:0] p, input logic [1:0] c);
    logic ok;
    ok = 1'b0;
    case ({p, c})
      {PED_RED,   PED_GREEN}: ok = 1'b1;
      {PED_GREEN, PED_BLINK}: ok = 1'b1;
      {PED_BLINK, PED_RED}:   ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Required dwell of the code being left; code 11 has no valid dwell.
  function automatic logic [6:0] dwell_req(input logic ped, input logic [1:0] code);
    logic [6:0] r;
    r = '0;
    if (ped) begin
      case (code)
        PED_RED:   r = 7'(P_PRED);
        PED_GREEN: r = 7'(P_PGREEN);
        PED_BLINK: r = 7'(P_PBLINK);
        default:   r = '0;
      endcase
    end else begin
      case (code)
        CAR_RED:    r = 7'(P_RED);
        CAR_GREEN:  r = 7'(P_GREEN);
        CAR_YELLOW: r = 7'(P_YELLOW);
        default:    r = 7'(P_LEFT);
      endcase
    end
    return r;
  endfunction

  // Per-sample checks and next-state of lamp history, counters and flags
  always_comb begin
    prev_d  = cur;
    dwell_d = dwell_q;
    arm_d   = arm_q;
    ylf_d   = ylf_q;
    e_seq   = 1'b0;
    e_time  = 1'b0;
    p_code  = '0;
    c_code  = '0;
    legal   = 1'b0;
    exempt  = 1'b0;
    is_ped  = 1'b0;

    for (int unsigned k = 0; k < 4; k++) begin
      is_ped = (k % 2) == 1;
      p_code = prev_q[k];
      c_code = cur[k];
      legal  = is_ped ? ped_legal(p_code, c_code)
                      : car_legal(p_code, c_code, ylf_q[k / 2]);
      exempt = is_ped && (p_code == PED_BAD || c_code == PED_BAD);
      if (c_code != p_code) begin
        if (!legal && !exempt) e_seq = 1'b1;
        if (arm_q[k] && dwell_q[k] != dwell_req(is_ped, p_code)) e_time = 1'b1;
        if (legal && p_code == 2'b00) arm_d[k] = 1'b1;
        if (!is_ped && c_code == CAR_YELLOW) ylf_d[k / 2] = (p_code == CAR_LEFT);
        dwell_d[k] = 7'd1;
      end else if (dwell_q[k] != '1) begin
        dwell_d[k] = dwell_q[k] + 7'd1;
      end
    end

    e_conf = (n_car != CAR_RED && e_car != CAR_RED)
          || (n_ped != PED_RED && n_car != CAR_RED)
          || (e_ped != PED_RED && e_car != CAR_RED);
    e_code = (n_ped == PED_BAD) || (s_ped == PED_BAD)
          || (e_ped == PED_BAD) || (w_ped == PED_BAD);
    e_pair = (n_car != s_car) || (n_ped != s_ped)
          || (e_car != w_car) || (e_ped != w_ped);

    cyc_next = {1'b0, cyc_q} + 8'd1;
    if (cyc_q == '0)                e_jump = (i_cycle > 7'd1);
    else if (cyc_q == 7'(P_FRAME))  e_jump = (i_cycle != 7'd1);
    else                            e_jump = ({1'b0, i_cycle} != cyc_next);

    new_err = {e_conf, e_code, e_seq, e_time, e_pair, e_jump};
    new_any = |new_err;

    // A clear in the same sample as a new error keeps that error
    if (i_clr) begin
      flags_d = new_err;
      cnt_d   = {7'd0, new_any};
      ecyc_d  = new_any ? i_cycle : '0;
    end else begin
      flags_d = flags_q | new_err;
      cnt_d   = (new_any && cnt_q != '1) ? cnt_q + 8'd1 : cnt_q;
      ecyc_d  = (new_any && flags_q == '0) ? i_cycle : ecyc_q;
    end
    any_d = |flags_d;
  end

  // State register; reset overrides every check in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      dwell_q <= '0;
      arm_q   <= '0;
      ylf_q   <= '0;
      cyc_q   <= '0;
      flags_q <= '0;
      any_q   <= 1'b0;
      ecyc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
      arm_q   <= arm_d;
      ylf_q   <= ylf_d;
      cyc_q   <= i_cycle;
      flags_q <= flags_d;
      any_q   <= any_d;
      ecyc_q  <= ecyc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_err_conf     = flags_q[5];
  assign o_err_code     = flags_q[4];
  assign o_err_seq      = flags_q[3];
  assign o_err_time     = flags_q[2];
  assign o_err_pair     = flags_q[1];
  assign o_err_cyc_jump = flags_q[0];
  assign o_err_any      = any_q;
  assign o_err_cyc      = ecyc_q;
  assign o_err_cnt      = cnt_q;

endmodule

// File: tb/tb_traffic_checker.sv
// Testbench for traffic_checker: directed scenarios plus randomized fault
// injection on a legal controller schedule, scored against a reference model.
module tb_traffic_checker;

  localparam int FR = 68;

  logic       clk = 1'b0;
  logic       rst, i_clr;
  logic [1:0] n_car, s_car, e_car, w_car, n_ped, s_ped, e_ped, w_ped;
  logic [6:0] i_cycle;
  logic       o_err_conf, o_err_code, o_err_seq, o_err_time, o_err_pair;
  logic       o_err_cyc_jump, o_err_any;
  logic [6:0] o_err_cyc;
  logic [7:0] o_err_cnt;

  always #5 clk = ~clk;

  traffic_checker #(
    .P_FRAME(68), .P_GREEN(20), .P_YELLOW(2), .P_LEFT(10), .P_RED(34),
    .P_PGREEN(14), .P_PBLINK(6), .P_PRED(48)
  ) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr),
    .n_car(n_car), .s_car(s_car), .e_car(e_car), .w_car(w_car),
    .n_ped(n_ped), .s_ped(s_ped), .e_ped(e_ped), .w_ped(w_ped),
    .i_cycle(i_cycle),
    .o_err_conf(o_err_conf), .o_err_code(o_err_code), .o_err_seq(o_err_seq),
    .o_err_time(o_err_time), .o_err_pair(o_err_pair),
    .o_err_cyc_jump(o_err_cyc_jump), .o_err_any(o_err_any),
    .o_err_cyc(o_err_cyc), .o_err_cnt(o_err_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [21:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_prev[4];
  int       m_last[4];   // sample index of the last code change
  bit       m_arm[4];
  int       m_orig[2];   // code the current yellow was entered from
  int       m_pcyc;
  int       m_n = 0;
  bit [5:0] m_flags;
  int       m_cnt, m_ecyc;

  function automatic bit car_ok(int p, int c, int orig);
    return (p == 0 && c == 1) || (p == 1 && c == 2) || (p == 3 && c == 2)
        || (p == 2 && c == 3 && orig != 3) || (p == 2 && c == 0 && orig == 3);
  endfunction

  function automatic bit ped_ok(int p, int c);
    return (p == 0 && c == 1) || (p == 1 && c == 2) || (p == 2 && c == 0);
  endfunction

  function automatic int req(bit ped, int code);
    int car_t[4] = '{34, 20, 2, 10};
    int ped_t[4] = '{48, 14, 6, 0};
    return ped ? ped_t[code] : car_t[code];
  endfunction

  task automatic model_push();
    int cur[4];
    int p, c, dw;
    bit ped, ok, cf, cd, sq, tm, pr, jp;
    bit [5:0] nw;
    cur = '{int'(n_car), int'(n_ped), int'(e_car), int'(e_ped)};
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_prev[k] = 0; m_last[k] = m_n + 1; m_arm[k] = 0;
      end
      m_orig = '{1, 1};
      m_pcyc = 0; m_flags = '0; m_cnt = 0; m_ecyc = 0;
    end else begin
      cf = (n_car != 0 && e_car != 0) || (n_ped != 0 && n_car != 0) || (e_ped != 0 && e_car != 0);
      cd = (n_ped == 3) || (s_ped == 3) || (e_ped == 3) || (w_ped == 3);
      pr = (n_car != s_car) || (n_ped != s_ped) || (e_car != w_car) || (e_ped != w_ped);
      if (m_pcyc == 0)       jp = !(int'(i_cycle) <= 1);
      else if (m_pcyc == FR) jp = (int'(i_cycle) != 1);
      else                   jp = (int'(i_cycle) != m_pcyc + 1);
      sq = 0; tm = 0;
      for (int k = 0; k < 4; k++) begin
        p = m_prev[k]; c = cur[k]; ped = (k % 2 == 1);
        if (c != p) begin
          ok = ped ? ped_ok(p, c) : car_ok(p, c, m_orig[k / 2]);
          if (!ok && !(ped && (p == 3 || c == 3))) sq = 1;
          dw = m_n - m_last[k];
          if (dw > 127) dw = 127;
          if (m_arm[k] && dw != req(ped, p)) tm = 1;
          if (ok && p == 0) m_arm[k] = 1;
          if (!ped && c == 2) m_orig[k / 2] = p;
          m_last[k] = m_n;
        end
        m_prev[k] = c;
      end
      m_pcyc = int'(i_cycle);
      nw = {cf, cd, sq, tm, pr, jp};
      if (i_clr) begin
        m_flags = nw;
        m_cnt   = (nw != 0) ? 1 : 0;
        m_ecyc  = (nw != 0) ? int'(i_cycle) : 0;
      end else if (nw != 0) begin
        if (m_flags == 0) m_ecyc = int'(i_cycle);
        m_flags = m_flags | nw;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_n++;
    exp_q.push_back({m_flags, |m_flags, 7'(m_ecyc), 8'(m_cnt)});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [21:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scoreboard", {10'd0, o_err_conf, o_err_code, o_err_seq, o_err_time, o_err_pair,
                         o_err_cyc_jump, o_err_any, o_err_cyc, o_err_cnt}, {10'd0, e});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    model_push();
    #1;
  endtask

  // Legal controller schedule for cycle c (0 = idle, all red)
  task automatic set_frame(input int c);
    logic [1:0] nc, ec, np, ep;
    nc = 0; ec = 0; np = 0; ep = 0;
    if (c >= 1 && c <= 20) nc = 1;
    else if ((c >= 21 && c <= 22) || (c >= 33 && c <= 34)) nc = 2;
    else if (c >= 23 && c <= 32) nc = 3;
    if (c >= 35 && c <= 54) ec = 1;
    else if ((c >= 55 && c <= 56) || (c >= 67 && c <= 68)) ec = 2;
    else if (c >= 57 && c <= 66) ec = 3;
    if (c >= 35 && c <= 48) np = 1;
    else if (c >= 49 && c <= 54) np = 2;
    if (c >= 1 && c <= 14) ep = 1;
    else if (c >= 15 && c <= 20) ep = 2;
    n_car = nc; s_car = nc; e_car = ec; w_car = ec;
    n_ped = np; s_ped = np; e_ped = ep; w_ped = ep;
    i_cycle = 7'(c);
  endtask

  task automatic run(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      set_frame(c);
      step();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_frame(0);
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_clr = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_clr = 1'b0;
    set_frame(0);
    step();
    step();
    chk("reset_any", 32'(o_err_any), 0);
    chk("reset_cnt", 32'(o_err_cnt), 0);
    chk("reset_cyc", 32'(o_err_cyc), 0);
    rst = 1'b0;

    // three clean frames
    idle(3);
    for (int f = 0; f < 3; f++) run(1, FR);
    chk("clean_any", 32'(o_err_any), 0);
    chk("clean_cnt", 32'(o_err_cnt), 0);

    // cross-axis conflict at cycle 5
    do_reset(); idle(2); run(1, 4);
    set_frame(5); e_car = 2'd1; w_car = 2'd1; step();
    chk("conf_flag", 32'(o_err_conf), 1);
    chk("conf_cyc", 32'(o_err_cyc), 5);
    chk("conf_cnt", 32'(o_err_cnt), 1);
    chk("conf_others", 32'({o_err_code, o_err_seq, o_err_time, o_err_pair, o_err_cyc_jump}), 0);

    // yellow held for a single cycle
    do_reset(); idle(2); run(1, 21);
    set_frame(22); n_car = 2'd3; s_car = 2'd3; step();
    chk("short_yel_time", 32'(o_err_time), 1);
    chk("short_yel_cyc", 32'(o_err_cyc), 22);
    chk("short_yel_seq", 32'(o_err_seq), 0);

    // GREEN -> LEFT directly
    do_reset(); idle(2); run(1, 20);
    set_frame(21); n_car = 2'd3; s_car = 2'd3; step();
    chk("g2l_seq", 32'(o_err_seq), 1);
    chk("g2l_time", 32'(o_err_time), 0);

    // illegal ped code on both N and S
    do_reset(); idle(2);
    set_frame(0); n_ped = 2'd3; s_ped = 2'd3; step();
    chk("code_flag", 32'(o_err_code), 1);
    chk("code_others", 32'({o_err_conf, o_err_seq, o_err_time, o_err_pair, o_err_cyc_jump}), 0);

    // pair mismatch at cycle 40
    do_reset(); idle(1); run(1, 39);
    set_frame(40); s_car = 2'd1; step();
    chk("pair_flag", 32'(o_err_pair), 1);
    chk("pair_cyc", 32'(o_err_cyc), 40);

    // cycle jump 10 -> 12
    do_reset(); idle(1); run(1, 10);
    set_frame(12); step();
    chk("jump_skip", 32'(o_err_cyc_jump), 1);
    chk("jump_skip_cyc", 32'(o_err_cyc), 12);

    // cycle jump 68 -> 0
    do_reset(); idle(1); run(1, FR);
    set_frame(FR); i_cycle = 7'd0; step();
    chk("jump_wrap0", 32'(o_err_cyc_jump), 1);
    chk("jump_wrap0_cnt", 32'(o_err_cnt), 1);

    // clear in the same sample as a conflict
    do_reset(); idle(1);
    for (int i = 0; i < 3; i++) begin set_frame(0); s_car = 2'd1; step(); end
    chk("pre_clr_cnt", 32'(o_err_cnt), 3);
    set_frame(0); n_car = 2'd1; s_car = 2'd1; e_car = 2'd1; w_car = 2'd1; i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    chk("clr_conf", 32'(o_err_conf), 1);
    chk("clr_pair", 32'(o_err_pair), 0);
    chk("clr_cnt", 32'(o_err_cnt), 1);

    // counter saturation
    do_reset(); idle(1);
    for (int i = 0; i < 300; i++) begin set_frame(0); s_car = 2'd1; step(); end
    chk("sat_cnt", 32'(o_err_cnt), 255);

    // randomized fault injection over a legal schedule
    do_reset(); idle(2);
    for (int f = 0; f < 4; f++) begin
      for (int c = 1; c <= FR; c++) begin
        set_frame(c);
        if ($urandom_range(0, 14) == 0) begin
          case ($urandom_range(0, 8))
            0: n_car = 2'($urandom_range(0, 3));
            1: s_car = 2'($urandom_range(0, 3));
            2: e_car = 2'($urandom_range(0, 3));
            3: w_car = 2'($urandom_range(0, 3));
            4: n_ped = 2'($urandom_range(0, 2));
            5: s_ped = 2'($urandom_range(0, 2));
            6: e_ped = 2'($urandom_range(0, 2));
            7: w_ped = 2'($urandom_range(0, 2));
            default: i_cycle = 7'($urandom_range(0, FR));
          endcase
        end
        i_clr = ($urandom_range(0, 39) == 0);
        rst   = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    rst = 1'b0;
    i_clr = 1'b0;
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
